// File: rtl/rv_id_stage.sv
// rv_id_stage: RV32I instruction-decode stage.
// Holds the 32x32 integer register file (two combinational read ports, one
// falling-edge write port fed from writeback) and the immediate sign-extender.
// Optional feature: define RF_BYPASS_EN to forward the writeback result
// combinationally to a read port whose source register matches RdW.
module rv_id_stage #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            RegWriteW,
  input  logic [31:0]     InstrD,
  input  logic [1:0]      ImmSrcD,
  input  logic [XLEN-1:0] ResultW,
  input  logic [4:0]      RdW,
  output logic [XLEN-1:0] RD1D,
  output logic [XLEN-1:0] RD2D,
  output logic [XLEN-1:0] ImmExtD
);

  logic [XLEN-1:0] regsQ [NREGS];
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic            wrValid;
  logic [XLEN-1:0] rfRd1;
  logic [XLEN-1:0] rfRd2;

  // Opcode bits play no part in reads or immediate extraction here.
  logic unusedOpcode;
  assign unusedOpcode = ^InstrD[6:0];

  assign rs1     = InstrD[19:15];
  assign rs2     = InstrD[24:20];
  assign wrValid = RegWriteW && (RdW != 5'd0);

  // Register file write on the falling edge so W results are visible to D
  // in the second half of the same cycle; reset clears everything at once.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREGS); i++) begin
        regsQ[i] <= '0;
      end
    end else if (wrValid) begin
      regsQ[RdW] <= ResultW;
    end
  end

  // Raw array reads with x0 forced to zero.
  always_comb begin
    rfRd1 = '0;
    rfRd2 = '0;
    if (rs1 != 5'd0) rfRd1 = regsQ[rs1];
    if (rs2 != 5'd0) rfRd2 = regsQ[rs2];
  end

`ifdef RF_BYPASS_EN
  // Read ports: forward the writeback value for the whole cycle on a match.
  always_comb begin
    RD1D = rfRd1;
    RD2D = rfRd2;
    if (wrValid && (RdW == rs1)) RD1D = ResultW;
    if (wrValid && (RdW == rs2)) RD2D = ResultW;
  end
`else
  // Read ports: no bypass; the falling-edge write alone provides W->D visibility.
  always_comb begin
    RD1D = rfRd1;
    RD2D = rfRd2;
  end
`endif

  // Immediate extraction and sign extension; bit 31 is always the sign.
  always_comb begin
    ImmExtD = '0;
    case (ImmSrcD)
      2'b00:   ImmExtD = {{20{InstrD[31]}}, InstrD[31:20]};
      2'b01:   ImmExtD = {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
      2'b10:   ImmExtD = {{20{InstrD[31]}}, InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0};
      2'b11:   ImmExtD = {{12{InstrD[31]}}, InstrD[19:12], InstrD[20], InstrD[30:21], 1'b0};
      default: ImmExtD = '0;
    endcase
  end

endmodule

// File: tb/tb_rv_id_stage.sv
// tb_rv_id_stage: directed self-checking bench for rv_id_stage.
// Inputs change 1 time unit after posedge; the "early" sample is taken before
// the falling edge, the "late" sample 1 time unit after it.
module tb_rv_id_stage;

  logic        clk;
  logic        rst_n;
  logic        RegWriteW;
  logic [31:0] InstrD;
  logic [1:0]  ImmSrcD;
  logic [31:0] ResultW;
  logic [4:0]  RdW;
  logic [31:0] RD1D;
  logic [31:0] RD2D;
  logic [31:0] ImmExtD;

  int checks = 0;
  int errors = 0;

  rv_id_stage dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .RegWriteW (RegWriteW),
    .InstrD    (InstrD),
    .ImmSrcD   (ImmSrcD),
    .ResultW   (ResultW),
    .RdW       (RdW),
    .RD1D      (RD1D),
    .RD2D      (RD2D),
    .ImmExtD   (ImmExtD)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive_slot();
    @(posedge clk);
    #1;
  endtask

  task automatic after_neg();
    @(negedge clk);
    #1;
  endtask

  // One falling-edge write, then write enable dropped.
  task automatic write_reg(input logic [4:0] rd, input logic [31:0] val);
    drive_slot();
    RegWriteW = 1'b1;
    RdW       = rd;
    ResultW   = val;
    after_neg();
    RegWriteW = 1'b0;
  endtask

  task automatic test_reset();
    drive_slot();
    InstrD  = 32'h00C00193;
    ImmSrcD = 2'b00;
    #2;
    checks++;
    if (RD1D !== 32'h0) begin
      errors++;
      $display("FAIL reset_rd1: got %h expected %h", RD1D, 32'h0);
    end
    checks++;
    if (RD2D !== 32'h0) begin
      errors++;
      $display("FAIL reset_rd2: got %h expected %h", RD2D, 32'h0);
    end
    checks++;
    if (ImmExtD !== 32'h0000000C) begin
      errors++;
      $display("FAIL reset_imm: got %h expected %h", ImmExtD, 32'h0000000C);
    end
    drive_slot();
    rst_n = 1'b1;
  endtask

  task automatic test_write_read();
    write_reg(5'd3, 32'd12);
    InstrD  = 32'hFF718393;
    ImmSrcD = 2'b00;
    #1;
    checks++;
    if (RD1D !== 32'd12) begin
      errors++;
      $display("FAIL wr_rd1_x3: got %h expected %h", RD1D, 32'd12);
    end
    checks++;
    if (RD2D !== 32'h0) begin
      errors++;
      $display("FAIL wr_rd2_x23: got %h expected %h", RD2D, 32'h0);
    end
    checks++;
    if (ImmExtD !== 32'hFFFFFFF7) begin
      errors++;
      $display("FAIL wr_imm: got %h expected %h", ImmExtD, 32'hFFFFFFF7);
    end
  endtask

  task automatic test_x0_protect();
    write_reg(5'd0, 32'hDEADBEEF);
    InstrD  = 32'h00500113;
    ImmSrcD = 2'b00;
    #1;
    checks++;
    if (RD1D !== 32'h0) begin
      errors++;
      $display("FAIL x0_rd1: got %h expected %h", RD1D, 32'h0);
    end
    checks++;
    if (RD2D !== 32'h0) begin
      errors++;
      $display("FAIL x0_rd2_x5: got %h expected %h", RD2D, 32'h0);
    end
    checks++;
    if (ImmExtD !== 32'h00000005) begin
      errors++;
      $display("FAIL x0_imm: got %h expected %h", ImmExtD, 32'h00000005);
    end
  endtask

  task automatic test_immediates();
    drive_slot();
    InstrD  = 32'hFE112E23;
    ImmSrcD = 2'b01;
    #1;
    checks++;
    if (ImmExtD !== 32'hFFFFFFFC) begin
      errors++;
      $display("FAIL imm_s: got %h expected %h", ImmExtD, 32'hFFFFFFFC);
    end
    ImmSrcD = 2'b00;
    #1;
    checks++;
    if (ImmExtD !== 32'hFFFFFFE1) begin
      errors++;
      $display("FAIL imm_i_neg: got %h expected %h", ImmExtD, 32'hFFFFFFE1);
    end
    InstrD  = 32'hFE000EE3;
    ImmSrcD = 2'b10;
    #1;
    checks++;
    if (ImmExtD !== 32'hFFFFFFFC) begin
      errors++;
      $display("FAIL imm_b: got %h expected %h", ImmExtD, 32'hFFFFFFFC);
    end
    InstrD  = 32'h0080006F;
    ImmSrcD = 2'b11;
    #1;
    checks++;
    if (ImmExtD !== 32'h00000008) begin
      errors++;
      $display("FAIL imm_j: got %h expected %h", ImmExtD, 32'h00000008);
    end
    ImmSrcD = 2'b00;
  endtask

  task automatic test_same_cycle_hazard();
    logic [31:0] earlyExp;
    write_reg(5'd5, 32'd3);
    drive_slot();
    InstrD    = 32'h00528093;  // rs1 = rs2 = x5
    RegWriteW = 1'b1;
    RdW       = 5'd5;
    ResultW   = 32'd7;
`ifdef RF_BYPASS_EN
    earlyExp = 32'd7;
`else
    earlyExp = 32'd3;
`endif
    #2;
    checks++;
    if (RD1D !== earlyExp) begin
      errors++;
      $display("FAIL hazard_rd1_early: got %h expected %h", RD1D, earlyExp);
    end
    checks++;
    if (RD2D !== earlyExp) begin
      errors++;
      $display("FAIL hazard_rd2_early: got %h expected %h", RD2D, earlyExp);
    end
    after_neg();
    checks++;
    if (RD1D !== 32'd7) begin
      errors++;
      $display("FAIL hazard_rd1_late: got %h expected %h", RD1D, 32'd7);
    end
    checks++;
    if (RD2D !== 32'd7) begin
      errors++;
      $display("FAIL hazard_rd2_late: got %h expected %h", RD2D, 32'd7);
    end
    RegWriteW = 1'b0;
  endtask

  task automatic test_back_to_back();
    drive_slot();
    RegWriteW = 1'b1;
    RdW       = 5'd10;
    ResultW   = 32'hA5A5_0001;
    after_neg();
    drive_slot();
    RdW     = 5'd11;
    ResultW = 32'h5A5A_0002;
    after_neg();
    RegWriteW = 1'b0;
    RdW       = 5'd12;
    ResultW   = 32'h1234_5678;
    InstrD    = 32'h00B50033;  // rs1 = x10, rs2 = x11
    #1;
    checks++;
    if (RD1D !== 32'hA5A5_0001) begin
      errors++;
      $display("FAIL b2b_x10: got %h expected %h", RD1D, 32'hA5A5_0001);
    end
    checks++;
    if (RD2D !== 32'h5A5A_0002) begin
      errors++;
      $display("FAIL b2b_x11: got %h expected %h", RD2D, 32'h5A5A_0002);
    end
    after_neg();
    InstrD = 32'h00060033;  // rs1 = x12 with write enable low
    #1;
    checks++;
    if (RD1D !== 32'h0) begin
      errors++;
      $display("FAIL b2b_we_low_x12: got %h expected %h", RD1D, 32'h0);
    end
  endtask

  task automatic test_async_reset();
    drive_slot();
    InstrD = 32'h00B50033;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (RD1D !== 32'h0) begin
      errors++;
      $display("FAIL areset_rd1: got %h expected %h", RD1D, 32'h0);
    end
    checks++;
    if (RD2D !== 32'h0) begin
      errors++;
      $display("FAIL areset_rd2: got %h expected %h", RD2D, 32'h0);
    end
    RegWriteW = 1'b1;
    RdW       = 5'd10;
    ResultW   = 32'd55;
    after_neg();
    checks++;
    if (RD1D !== 32'h0) begin
      errors++;
      $display("FAIL areset_write_lost: got %h expected %h", RD1D, 32'h0);
    end
    RegWriteW = 1'b0;
    drive_slot();
    rst_n = 1'b1;
    write_reg(5'd10, 32'd99);
    #1;
    checks++;
    if (RD1D !== 32'd99) begin
      errors++;
      $display("FAIL areset_post_write: got %h expected %h", RD1D, 32'd99);
    end
    checks++;
    if (RD2D !== 32'h0) begin
      errors++;
      $display("FAIL areset_x11_cleared: got %h expected %h", RD2D, 32'h0);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    RegWriteW = 1'b0;
    InstrD    = 32'h0;
    ImmSrcD   = 2'b00;
    ResultW   = 32'h0;
    RdW       = 5'd0;
    test_reset();
    test_write_read();
    test_x0_protect();
    test_immediates();
    test_same_cycle_hazard();
    test_back_to_back();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
